// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned WIDTH_DEFAULT = 8;

  // Counter must index bit positions 0..width-1
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif

endinterface

// File: rtl/serial_adder_fa_cell.sv
// Single combinational 1-bit full-adder cell.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);

  assign s = a ^ b ^ cin;
  assign c = (a & b) | ((a ^ b) & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first through one full-adder cell with a registered carry.
// Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);

  localparam int unsigned    CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             fa_s, fa_c;
  logic             last_bit;

  fa_cell u_fa (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .c   (fa_c)
  );

  assign last_bit = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = SHIFT;
      SHIFT:   if (last_bit)      state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
      SHIFT: begin
        // Sum bits enter at the MSB so bit 0 lands in place after WIDTH shifts
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_c;
        cnt_d   = cnt_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic c_msb_q, c_msb_d;

  // Carry into the MSB is the carry register during the last SHIFT cycle
  always_comb begin
    c_msb_d = c_msb_q;
    if (state_q == IDLE && bus.in_valid)  c_msb_d = 1'b0;
    else if (state_q == SHIFT && last_bit) c_msb_d = carry_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) c_msb_q <= 1'b0;
    else     c_msb_q <= c_msb_d;
  end
`endif

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.sum       = sum_q;
    bus.cout      = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
    bus.ovf       = (state_q == DONE) & (c_msb_q ^ carry_q);
`endif
  end

endmodule
